// File: rtl/pueo_beam_threshold_v3.sv
// Threshold stage for beamformer envelopes: NBEAM x NTHRESH comparators against
// double-buffered thresholds, with per-output masking and retrigger holdoff.
module pueo_beam_threshold_v3 #(
    parameter int NBEAM    = 2,
    parameter int NTHRESH  = 2,
    parameter int ENVBITS  = 17,
    parameter int THBITS   = 18,
    parameter int HOLDOFF  = 4,
    localparam int NOUT     = NBEAM * NTHRESH,
    localparam int ADDRBITS = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NBEAM*ENVBITS-1:0]   envelope_i,
    input  logic [ADDRBITS-1:0]        thresh_addr_i,
    input  logic [THBITS-1:0]          thresh_dat_i,
    input  logic                       thresh_wr_i,
    input  logic                       thresh_update_i,
    input  logic [NOUT-1:0]            mask_i,
    output logic [NOUT-1:0]            trigger_o,
    output logic                       trig_any_o,
    output logic                       pending_o
);

    localparam logic [ADDRBITS:0] NOUT_W    = (ADDRBITS + 1)'(NOUT);
    localparam logic [7:0]        HOLD_INIT = 8'(HOLDOFF);

    logic [NBEAM*ENVBITS-1:0] env_q;
    logic [NOUT-1:0]          trig_d;
    logic [NOUT-1:0]          trig_q;
    logic                     trig_any_q;
    logic                     pending_d;
    logic                     pending_q;
    logic                     wr_ok;

    // Out-of-range addresses are dropped entirely, including their effect on pending.
    assign wr_ok = thresh_wr_i && ({1'b0, thresh_addr_i} < NOUT_W);

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
            localparam int BEAM = gi / NTHRESH;

            logic [THBITS-1:0] shadow_q;
            logic [THBITS-1:0] shadow_d;
            logic [THBITS-1:0] active_q;
            logic [THBITS-1:0] active_d;
            logic [THBITS-1:0] env_ext;
            logic [7:0]        hold_q;
            logic [7:0]        hold_d;
            logic              wr_sel;
            logic              hit;
            logic              fire;

            assign env_ext = THBITS'(env_q[BEAM*ENVBITS +: ENVBITS]);
            assign wr_sel  = wr_ok && (thresh_addr_i == ADDRBITS'(gi));
            assign hit     = env_ext > active_q;
            assign fire    = hit & ~mask_i[gi] & (hold_q == 8'd0);
            assign trig_d[gi] = fire;

            // Update copies the pre-write shadow, so a same-cycle write stays pending.
            always_comb begin
                shadow_d = shadow_q;
                active_d = active_q;
                hold_d   = hold_q;
                if (thresh_update_i) begin
                    active_d = shadow_q;
                end
                if (wr_sel) begin
                    shadow_d = thresh_dat_i;
                end
                if (fire) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    shadow_q <= '1;
                    active_q <= '1;
                    hold_q   <= 8'd0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    hold_q   <= hold_d;
                end
            end
        end
    endgenerate

    always_comb begin
        pending_d = pending_q;
        if (wr_ok) begin
            pending_d = 1'b1;
        end else if (thresh_update_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            env_q      <= '0;
            trig_q     <= '0;
            trig_any_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            env_q      <= envelope_i;
            trig_q     <= trig_d;
            trig_any_q <= |trig_d;
            pending_q  <= pending_d;
        end
    end

    assign trigger_o  = trig_q;
    assign trig_any_o = trig_any_q;
    assign pending_o  = pending_q;

endmodule

// File: tb/tb_pueo_beam_threshold_v3.sv
// Directed bench for pueo_beam_threshold_v3 with 3 beams x 2 thresholds, HOLDOFF=4.
module tb_pueo_beam_threshold_v3;

    localparam int NB = 3;
    localparam int NT = 2;
    localparam int EB = 17;
    localparam int TB = 18;
    localparam int NO = NB * NT;
    localparam int AB = 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NB*EB-1:0]  envelope = '0;
    logic [AB-1:0]     thresh_addr = '0;
    logic [TB-1:0]     thresh_dat = '0;
    logic              thresh_wr = 1'b0;
    logic              thresh_update = 1'b0;
    logic [NO-1:0]     mask = '0;
    logic [NO-1:0]     trigger;
    logic              trig_any;
    logic              pending;

    int total = 0;
    int bad   = 0;

    pueo_beam_threshold_v3 #(
        .NBEAM(NB), .NTHRESH(NT), .ENVBITS(EB), .THBITS(TB), .HOLDOFF(4)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .envelope_i(envelope),
        .thresh_addr_i(thresh_addr),
        .thresh_dat_i(thresh_dat),
        .thresh_wr_i(thresh_wr),
        .thresh_update_i(thresh_update),
        .mask_i(mask),
        .trigger_o(trigger),
        .trig_any_o(trig_any),
        .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_env(input int b, input logic [EB-1:0] v);
        envelope[b*EB +: EB] = v;
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [TB-1:0] d);
        thresh_wr = 1'b1;
        thresh_addr = a;
        thresh_dat = d;
        tick();
        thresh_wr = 1'b0;
    endtask

    task automatic upd();
        thresh_update = 1'b1;
        tick();
        thresh_update = 1'b0;
    endtask

    task automatic drain();
        envelope = '0;
        for (int i = 0; i < 7; i++) tick();
    endtask

    initial begin
        // reset state
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_trig", 32'(trigger), 32'h0);
        chk("rst_any", 32'(trig_any), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        rstn = 1'b1;

        // unprogrammed thresholds are all ones: max envelope never triggers
        for (int b = 0; b < NB; b++) set_env(b, 17'h1FFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("unprog_trig%0d", i), 32'(trigger), 32'h0);
        end
        chk("unprog_pend", 32'(pending), 32'h0);
        envelope = '0;
        tick();

        wr(3'd0, 18'd1000);
        chk("wr0_pend", 32'(pending), 32'h1);
        wr(3'd1, 18'd2000);
        chk("wr1_pend", 32'(pending), 32'h1);
        upd();
        chk("upd_pend", 32'(pending), 32'h0);

        // equal to threshold is not a hit
        set_env(0, 17'd1000);
        tick(); tick();
        chk("eq_thr", 32'(trigger), 32'h0);
        set_env(0, 17'd1001);
        tick();
        chk("lat_n1", 32'(trigger), 32'h0);
        tick();
        chk("gt_thr0", 32'(trigger), 32'h01);
        chk("gt_thr0_any", 32'(trig_any), 32'h1);
        drain();
        set_env(0, 17'd2001);
        tick(); tick();
        chk("gt_both", 32'(trigger), 32'h03);
        drain();

        // holdoff: pulses at N+2, N+7, N+12
        set_env(0, 17'd5000);
        tick(); tick();
        chk("hold_n2", 32'(trigger), 32'h03);
        for (int c = 3; c <= 12; c++) begin
            tick();
            chk($sformatf("hold_n%0d", c), 32'(trigger), (c == 7 || c == 12) ? 32'h03 : 32'h0);
            chk($sformatf("hold_any_n%0d", c), 32'(trig_any), (c == 7 || c == 12) ? 32'h1 : 32'h0);
        end
        drain();

        // write + update together: update takes old shadow (1000), write stays pending
        thresh_wr = 1'b1; thresh_addr = 3'd0; thresh_dat = 18'd10; thresh_update = 1'b1;
        tick();
        thresh_wr = 1'b0; thresh_update = 1'b0;
        chk("wu_pend", 32'(pending), 32'h1);
        set_env(0, 17'd500);
        tick(); tick();
        chk("wu_active_old", 32'(trigger), 32'h0);
        envelope = '0;
        upd();
        chk("wu_upd2_pend", 32'(pending), 32'h0);
        set_env(0, 17'd500);
        tick(); tick();
        chk("wu_active_new", 32'(trigger), 32'h01);
        drain();

        // out-of-range write ignored
        wr(3'd6, 18'd0);
        chk("oor_pend", 32'(pending), 32'h0);
        upd();
        for (int b = 0; b < NB; b++) set_env(b, 17'd5);
        tick(); tick();
        chk("oor_noeffect", 32'(trigger), 32'h0);
        drain();

        // mask: only bit 0 fires; clearing mask lets bit 1 fire next cycle
        mask = 6'b000010;
        set_env(0, 17'd5000);
        tick(); tick();
        chk("mask_on", 32'(trigger), 32'h01);
        mask = '0;
        tick();
        chk("mask_off", 32'(trigger), 32'h02);
        drain();

        // reset mid-holdoff; write/update during reset discarded
        set_env(0, 17'd5000);
        tick(); tick();
        chk("pre_rst", 32'(trigger), 32'h03);
        rstn = 1'b0;
        thresh_wr = 1'b1; thresh_addr = 3'd1; thresh_dat = 18'd0; thresh_update = 1'b1;
        tick();
        rstn = 1'b1;
        thresh_wr = 1'b0; thresh_update = 1'b0;
        chk("midrst_trig", 32'(trigger), 32'h0);
        chk("midrst_pend", 32'(pending), 32'h0);
        wr(3'd0, 18'd1000);
        upd();
        chk("postrst_n1", 32'(trigger), 32'h0);
        tick();
        chk("postrst_n2", 32'(trigger), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pueo_beam_threshold_v3.md
# pueo_beam_threshold_v3

Parametrised threshold stage for the beamformer's envelope outputs, generalising the fixed two-beam, two-threshold scheme to NBEAM beams × NTHRESH thresholds. It takes one envelope word per beam per clock and compares each against double-buffered, individually addressable thresholds. It applies a per-output mask and a per-output retrigger holdoff, and emits one-cycle trigger pulses. It sits directly after the envelope stage and feeds the trigger combiner. It replaces the cascaded DSP threshold chain with a fabric implementation.

## Interface
Parameters:
- NBEAM, 2, number of beams (1..48).
- NTHRESH, 2, thresholds per beam (1..4).
- ENVBITS, 17, envelope width (unsigned).
- THBITS, 18, threshold width (unsigned); ENVBITS ≤ THBITS.
- HOLDOFF, 4, cycles a trigger output is suppressed after it fires (0..255; 0 = none).
- localparam NOUT = NBEAM*NTHRESH; ADDRBITS = max(1, $clog2(NOUT)).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rstn_i  in  1  synchronous, active-low reset.
- envelope_i  in  NBEAM*ENVBITS  beam b at [b*ENVBITS +: ENVBITS]; new sample every clock.
- thresh_addr_i  in  ADDRBITS  shadow index = b*NTHRESH + t.
- thresh_dat_i  in  THBITS  threshold value.
- thresh_wr_i  in  1  write thresh_dat_i into shadow[thresh_addr_i].
- thresh_update_i  in  1  copy all shadow registers into active registers.
- mask_i  in  NOUT  1 = output forced off.
- trigger_o  out  NOUT  bit b*NTHRESH+t = beam b exceeded threshold t.
- trig_any_o  out  1  OR of trigger_o, same cycle.
- pending_o  out  1  shadow differs from active (write since last update).

## Operation
- Stage 1: register envelope_i (env_q), zero-extended to THBITS.
- Stage 2: for each output k = b*NTHRESH+t, compute hit_k = (env_q[b] > active[k]) — strict greater-than, unsigned.
- Output rule: trigger_o[k] <= hit_k & ~mask_i[k] & (hold_k == 0).
- Holdoff counter: when trigger_o[k] is loaded 1, hold_k <= HOLDOFF; otherwise it decrements while nonzero. A masked or suppressed hit does not reload hold_k. Counter width is 8 bits.
- Writes: thresh_wr_i with thresh_addr_i < NOUT sets shadow[addr] and pending_o. A write with addr ≥ NOUT is ignored and leaves pending_o unchanged.
- Update: thresh_update_i sets active[k] <= shadow[k] for all k and clears pending_o.
- Simultaneous write + update in the same cycle:
  - The update transfers the pre-write shadow contents.
  - The write still lands in shadow.
  - pending_o ends set.
- Reset (rstn_i low, sampled at an edge) applies the following:
  - shadow and active all ones, so no triggers until programmed.
  - env_q = 0.
  - hold_k = 0.
  - trigger_o = 0, trig_any_o = 0, pending_o = 0.
  - A write or update in a reset cycle is discarded.
- Reset mid-holdoff clears the holdoff. The first post-reset hit is then governed only by the thresholds, which are all ones after reset.
- mask_i is sampled at stage 2. A change takes effect on the next trigger_o update, with no holdoff side effects.

## Timing
- Latency: envelope_i in cycle N → trigger_o/trig_any_o in cycle N+2.
- Threshold visibility: the comparison for a sample presented in cycle N uses the active values after the edge ending cycle N. An update sampled in cycle N therefore applies to samples from cycle N onward. An update in cycle N+1 does not apply to that sample.
- Trigger pulses last one cycle per hit. A continuous above-threshold envelope gives a pulse every HOLDOFF+1 cycles, or every cycle when HOLDOFF = 0.
- pending_o changes on the edge after the write/update cycle.
- Everything is registered; no combinational input→output paths.

## Test plan
- Reset, then drive all envelopes to 0x1FFFF with no programming → trigger_o stays 0 (active = 0x3FFFF); pending_o = 0.
- Write shadow[0]=1000 and shadow[1]=2000 → pending_o = 1. Update → pending_o = 0. Drive beam0 envelope 1000 → no trigger. Drive 1001 in cycle N → trigger_o = 01b in cycle N+2. Drive 2001 → 11b.
- HOLDOFF=4, beam0 held at 5000 over threshold 1000 → trigger_o[0] pulses in cycles N+2, N+7, N+12; trig_any_o mirrors it.
- Write shadow[0]=10 and assert update in the same cycle → active[0] keeps the previous shadow value, pending_o = 1. A second update → active[0] = 10, pending_o = 0. A write to addr = NOUT is ignored.
- mask_i[1] = 1 with beam0 over both thresholds → only bit 0 pulses. Clearing the mask → bit 1 fires on the next cycle, with no inherited holdoff.
- Assert rstn_i low during holdoff, then release and reprogram threshold 0 to 1000 with beam0 at 5000 → the first trigger appears 2 cycles after the update cycle, with no residual holdoff.
